// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins and the debounce/typematic conditioner.
// The conditioner takes the slave side; the board or bench drives the master side.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_step;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_step
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_step
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-FF sync, counter debounce, press/release pulses and a typematic step pulse
// that auto-repeats on held buttons enabled in REPEAT_MASK.
module button_conditioner #(
    parameter int               N_BTN           = 4,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 40_000_000,
    parameter int               REPEAT_RATE     = 10_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(4'b0011)
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RP_W   = (RP_MAX > 2) ? $clog2(RP_MAX) : 1;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] RR_LAST = RP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, HELD, DELAY, RATE} rpt_state_e;

    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;
    logic [N_BTN-1:0] level_p2;
    logic [N_BTN-1:0] press_p2;
    logic [N_BTN-1:0] release_p2;
    logic [N_BTN-1:0] step_p2;

    // p0/p1: metastability synchroniser on the raw pins
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= bus.btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // p2: debounce, edge pulses and repeat FSM, all registered on the same edge
    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nxt;
        logic [RP_W-1:0] rcnt;
        logic [RP_W-1:0] rcnt_nxt;
        rpt_state_e      state;
        rpt_state_e      state_nxt;
        logic            level_q;
        logic            level_nxt;
        logic            press_q;
        logic            release_q;
        logic            step_q;
        logic            step_nxt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt       <= '0;
                rcnt      <= '0;
                state     <= IDLE;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
            end else begin
                cnt       <= cnt_nxt;
                rcnt      <= rcnt_nxt;
                state     <= state_nxt;
                level_q   <= level_nxt;
                press_q   <= level_nxt & ~level_q;
                release_q <= ~level_nxt & level_q;
                step_q    <= step_nxt;
            end
        end

        always_comb begin
            cnt_nxt   = '0;
            level_nxt = level_q;
            state_nxt = state;
            rcnt_nxt  = rcnt;
            step_nxt  = 1'b0;

            if (sync_p1[i] != level_q) begin
                if (cnt == DB_LAST) begin
                    level_nxt = sync_p1[i];
                end else begin
                    cnt_nxt = cnt + DB_W'(1);
                end
            end

            // Release dominates: a counter expiring on the release edge issues no step.
            if (!level_nxt) begin
                state_nxt = IDLE;
                rcnt_nxt  = '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!level_q) begin
                            step_nxt  = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = REPEAT_MASK[i] ? DELAY : HELD;
                        end
                    end
                    HELD: ;
                    DELAY: begin
                        if (rcnt == RD_LAST) begin
                            step_nxt  = 1'b1;
                            rcnt_nxt  = '0;
                            state_nxt = RATE;
                        end else begin
                            rcnt_nxt = rcnt + RP_W'(1);
                        end
                    end
                    RATE: begin
                        if (rcnt == RR_LAST) begin
                            step_nxt = 1'b1;
                            rcnt_nxt = '0;
                        end else begin
                            rcnt_nxt = rcnt + RP_W'(1);
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign level_p2[i]   = level_q;
        assign press_p2[i]   = press_q;
        assign release_p2[i] = release_q;
        assign step_p2[i]    = step_q;
    end

    assign bus.btn_level   = level_p2;
    assign bus.btn_press   = press_p2;
    assign bus.btn_release = release_p2;
    assign bus.btn_step    = step_p2;

endmodule
